// File: rtl/shift_tx_controller.sv
// Parallel-to-serial transmitter: accepts a WIDTH-bit word, shifts it out MSB first,
// holding each bit for BIT_CYCLES clocks, then pulses done for one cycle.
module shift_tx_controller #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             hold,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [7:0]       TICK_LAST = 8'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [7:0]       tick_cnt, tick_cnt_nxt;
  logic             run_q;
  logic             accept;

  // run_q re-times reset release onto clk: nothing can be accepted until the
  // first edge after rst rises, so the release edge itself never changes state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sreg     <= '0;
      bit_cnt  <= '0;
      tick_cnt <= '0;
    end else begin
      state    <= state_nxt;
      sreg     <= sreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      tick_cnt <= tick_cnt_nxt;
    end
  end

  assign accept = (state == IDLE) && run_q && din_valid;

  always_comb begin
    state_nxt    = state;
    sreg_nxt     = sreg;
    bit_cnt_nxt  = bit_cnt;
    tick_cnt_nxt = tick_cnt;
    din_ready    = 1'b0;
    busy         = 1'b0;
    sout         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        din_ready = run_q;
        if (accept) begin
          sreg_nxt     = din;
          bit_cnt_nxt  = '0;
          tick_cnt_nxt = '0;
          state_nxt    = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        sout = sreg[WIDTH-1];
        // hold freezes everything, including the terminal tick of a bit
        if (!hold) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_nxt = '0;
            sreg_nxt     = sreg << 1;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt_nxt = '0;
              state_nxt   = DONE;
            end else begin
              bit_cnt_nxt = bit_cnt + CNT_W'(1);
            end
          end else begin
            tick_cnt_nxt = tick_cnt + 8'd1;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_tx_controller.sv
// Scoreboard bench for shift_tx_controller: one instance at BIT_CYCLES=4, one at BIT_CYCLES=1.
module tb_shift_tx_controller;

  localparam int BC[2] = '{4, 1};

  typedef struct {
    logic [7:0] word;
    int         len;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       hold;
  logic       vld0, vld1;
  logic       rdy0, rdy1, sout0, sout1, busy0, busy1, done0, done1;

  logic busy_a[2], sout_a[2], done_a[2], rdy_a[2], vld_a[2];
  assign busy_a[0] = busy0;  assign busy_a[1] = busy1;
  assign sout_a[0] = sout0;  assign sout_a[1] = sout1;
  assign done_a[0] = done0;  assign done_a[1] = done1;
  assign rdy_a[0]  = rdy0;   assign rdy_a[1]  = rdy1;
  assign vld_a[0]  = vld0;   assign vld_a[1]  = vld1;

  exp_t q0[$], q1[$];
  int   acc0[$];
  int   cyc = 0;
  int   tests = 0, fails = 0;

  always #5 clk = ~clk;

  shift_tx_controller #(.WIDTH(8), .BIT_CYCLES(4)) u0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(vld0), .din_ready(rdy0),
    .hold(hold), .sout(sout0), .busy(busy0), .done(done0)
  );

  shift_tx_controller #(.WIDTH(8), .BIT_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(vld1), .din_ready(rdy1),
    .hold(hold), .sout(sout1), .busy(busy1), .done(done1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: collects sout on unheld busy cycles and scores each frame at done.
  int         cnt[2], ns[2];
  logic [63:0] smp[2];
  bit         pend[2], dprev[2];

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        cnt[i] = 0; ns[i] = 0; pend[i] = 0; dprev[i] = 0;
      end else begin
        if (pend[i]) begin
          check($sformatf("accept_latency%0d", i), busy_a[i], 1'b1);
          pend[i] = 0;
        end
        if (dprev[i]) begin
          check($sformatf("done_width%0d", i), done_a[i], 1'b0);
          check($sformatf("ready_after_done%0d", i), rdy_a[i], 1'b1);
          dprev[i] = 0;
        end
        if (busy_a[i]) begin
          cnt[i]++;
          if (!hold) begin
            if (ns[i] < 64) smp[i][ns[i]] = sout_a[i];
            ns[i]++;
          end
        end
        if (done_a[i]) begin
          dprev[i] = 1;
          check($sformatf("done_outs%0d", i), {busy_a[i], sout_a[i], rdy_a[i]}, 3'b000);
          if ((i == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
            check($sformatf("unexpected_done%0d", i), done_a[i], 1'b0);
          end else begin
            exp_t       e;
            logic [7:0] w;
            bit         uni;
            e   = (i == 0) ? q0.pop_front() : q1.pop_front();
            uni = 1;
            for (int k = 0; k < 8; k++) begin
              w[7-k] = smp[i][k*BC[i]];
              for (int j = 1; j < BC[i]; j++)
                if (smp[i][k*BC[i]+j] !== smp[i][k*BC[i]]) uni = 0;
            end
            check($sformatf("word%0d", i), w, e.word);
            check($sformatf("bit_uniform%0d", i), uni, 1'b1);
            check($sformatf("frame_len%0d", i), cnt[i], e.len);
            check($sformatf("unheld_cycles%0d", i), ns[i], 8 * BC[i]);
          end
          cnt[i] = 0; ns[i] = 0;
        end
        if (vld_a[i] && rdy_a[i]) begin
          pend[i] = 1;
          if (i == 0) acc0.push_back(cyc);
        end
      end
    end
  end

  task automatic send0(input logic [7:0] w, input int len);
    din  = w;
    vld0 = 1'b1;
    q0.push_back('{word: w, len: len});
    @(posedge clk); #1;
    vld0 = 1'b0;
  endtask

  task automatic wait_acc(input int n, input string name);
    int k;
    for (k = 0; k < 60; k++) begin
      if (acc0.size() >= n) break;
      @(posedge clk); #1;
    end
    if (acc0.size() < n) check(name, acc0.size(), n);
  endtask

  initial begin
    rst = 1'b0; din = '0; hold = 1'b0; vld0 = 1'b0; vld1 = 1'b0;
    #2;
    check("reset_outs0", {busy0, sout0, done0, rdy0}, 4'b0000);
    check("reset_outs1", {busy1, sout1, done1, rdy1}, 4'b0000);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", rdy0, 1'b1);

    // basic frame
    send0(8'hA5, 32);
    repeat (40) @(posedge clk); #1;

    // back-to-back with valid held
    acc0.delete();
    q0.push_back('{word: 8'hFF, len: 32});
    q0.push_back('{word: 8'h01, len: 32});
    din = 8'hFF; vld0 = 1'b1;
    @(posedge clk); #1;
    wait_acc(1, "b2b_first_timeout");
    din = 8'h01;
    wait_acc(2, "b2b_second_timeout");
    vld0 = 1'b0;
    if (acc0.size() >= 2) check("b2b_gap", acc0[1] - acc0[0], 34);
    repeat (40) @(posedge clk); #1;

    // hold for 5 cycles inside bit 3
    send0(8'h0F, 37);
    repeat (13) @(posedge clk); #1;
    hold = 1'b1;
    repeat (5) @(posedge clk); #1;
    hold = 1'b0;
    repeat (40) @(posedge clk); #1;

    // valid while busy is ignored, din changes don't leak
    send0(8'hC3, 32);
    repeat (10) @(posedge clk); #1;
    din = 8'h00; vld0 = 1'b1;
    check("ready_in_shift", rdy0, 1'b0);
    @(posedge clk); #1;
    vld0 = 1'b0; din = 8'h55;
    repeat (45) @(posedge clk); #1;

    // asynchronous reset during bit 5
    send0(8'hFF, 32);
    repeat (21) @(posedge clk); #1;
    check("pre_reset_sout", sout0, 1'b1);
    #3 rst = 1'b0;
    #1;
    check("abort_outs", {busy0, sout0, done0, rdy0}, 4'b0000);
    q0.delete();
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    send0(8'h81, 32);
    repeat (40) @(posedge clk); #1;

    // BIT_CYCLES=1 instance
    din = 8'h96; vld1 = 1'b1;
    q1.push_back('{word: 8'h96, len: 8});
    @(posedge clk); #1;
    vld1 = 1'b0;
    repeat (15) @(posedge clk); #1;

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_tx_controller.md
SHIFT_TX_CONTROLLER -- requirements
Module: shift_tx_controller

Interface
REQ-001 Parameter WIDTH, default 8: number of data bits per word, shifted MSB first.
REQ-002 Parameter BIT_CYCLES, default 4: clock cycles each bit is held on sout; legal range is 1 to 255.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1: reset, asynchronous assertion, active-low (0 = reset).
REQ-005 Port din  input  WIDTH: parallel word to serialize; sampled only on an accept.
REQ-006 Port din_valid  input  1: requester has a word on din.
REQ-007 Port din_ready  output  1: controller can accept a word this cycle.
REQ-008 Port hold  input  1: pauses shifting while high.
REQ-009 Port sout  output  1: serial data output; idle level 0.
REQ-010 Port busy  output  1: a word is being shifted.
REQ-011 Port done  output  1: single-cycle pulse after the last bit of a word completes.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 IDLE: din_ready=1, busy=0, sout=0, done=0.
REQ-014 Accept condition: din_valid=1 and din_ready=1 on a rising edge.
REQ-015 On accept: load din into the internal shift register, clear bit_cnt and tick_cnt, and go to SHIFT on that same edge.
REQ-016 SHIFT outputs: din_ready=0, busy=1, sout = current shift-register MSB.
REQ-017 Latency: the first bit (din[WIDTH-1]) SHALL appear on sout in the first cycle after the accept edge.
REQ-018 In SHIFT with hold=0, tick_cnt increments each cycle; when tick_cnt=BIT_CYCLES-1, tick_cnt wraps to 0, the register shifts left by one (0 fills the LSB), and bit_cnt increments.
REQ-019 In SHIFT with hold=1, tick_cnt, bit_cnt, the register and sout SHALL all freeze, including on the cycle that would otherwise be the last tick (hold wins).
REQ-020 The shift that completes bit WIDTH-1 (bit_cnt=WIDTH-1 at tick wrap) SHALL move SHIFT to DONE instead of continuing.
REQ-021 Frame length with hold=0 throughout: exactly WIDTH*BIT_CYCLES cycles in SHIFT; each bit is held exactly BIT_CYCLES cycles.
REQ-022 DONE lasts exactly one cycle: done=1, busy=0, sout=0, din_ready=0; it then goes to IDLE unconditionally.
REQ-023 Consequence of REQ-022: the minimum gap between consecutive accepts is WIDTH*BIT_CYCLES+2 cycles.
REQ-024 din_valid outside IDLE SHALL be ignored; din SHALL NOT be sampled and no state changes.
REQ-025 din changes during SHIFT SHALL NOT affect sout.
REQ-026 bit_cnt is ceil(log2(WIDTH+1)) bits and tick_cnt is 8 bits; neither counter may exceed its terminal value.
REQ-027 If BIT_CYCLES=1, a shift occurs every unheld cycle.
REQ-028 hold in IDLE or DONE has no effect.

Reset
REQ-029 While rst=0, independent of clk: state=IDLE, shift register=0, bit_cnt=0, tick_cnt=0, sout=0, busy=0, done=0.
REQ-030 din_ready SHALL be 0 while rst=0 and 1 from the first cycle after rst rises.
REQ-031 Reset asserted mid-SHIFT SHALL abort the word immediately with no done pulse; the next accept after release SHALL start a clean frame.
REQ-032 Reset release SHALL be taken synchronously to clk, so no transition occurs on the release edge itself.

Verification
REQ-033 Basic frame: WIDTH=8, BIT_CYCLES=4, din=8'hA5 for one valid cycle -> sout=1,0,1,0,0,1,0,1, each bit for 4 cycles, starting 1 cycle after accept; busy for 32 cycles; done=1 for 1 cycle; din_ready back to 1 in the next cycle.
REQ-034 Back-to-back: din_valid held at 1 with 8'hFF then 8'h01 -> second accept occurs exactly 34 cycles after the first; sout shows eight 1s, two cycles of 0, then 0000_0001.
REQ-035 Hold: during bit 3 of 8'h0F, assert hold for 5 cycles -> bit 3 lasts 4+5=9 cycles, frame lasts 37 cycles, and no bit is lost or duplicated.
REQ-036 Ignore while busy: pulse din_valid with 8'h00 mid-frame of 8'hC3 -> sout still shows 1100_0011, and no second frame follows.
REQ-037 Reset mid-op: drive rst=0 asynchronously (between clock edges) at bit 5 -> sout, busy and done drop to 0 immediately with no done pulse; after release, 8'h81 serializes correctly.
REQ-038 BIT_CYCLES=1 build: 8'h96 -> sout=1,0,0,1,0,1,1,0 on 8 consecutive cycles, then done.
